// File: rtl/mem_access_if.sv
// Data-bus interface between the memory-access stage (master) and the data memory (slave).
// Handshake: req/we/addr/be/wdata are held stable until gnt is seen high on a rising edge;
// for reads, rvalid qualifies rdata in a later cycle than gnt, never in the gnt cycle itself.
interface mem_access_if;
   logic        req;
   logic        we;
   logic [31:0] addr;
   logic [3:0]  be;
   logic [31:0] wdata;
   logic        gnt;
   logic        rvalid;
   logic [31:0] rdata;

   modport master (
      output req, we, addr, be, wdata,
      input  gnt, rvalid, rdata
   );

   modport slave (
      input  req, we, addr, be, wdata,
      output gnt, rvalid, rdata
   );
endinterface

// File: rtl/mem_access.sv
// Memory-access pipeline stage: runs EX/MEM load/store commands on the data bus,
// aligns/extends load data for MEM/WB and stalls the pipeline while the bus is busy.
module mem_access (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               mem_we_i,
   input  logic [31:0]        mem_addr_i,
   input  logic [31:0]        mem_data_i,
   input  logic [3:0]         mem_op_i,
   input  logic [4:0]         reg_waddr_i,
   input  logic               reg_we_i,
   input  logic [31:0]        reg_wdata_i,
   input  logic [5:0]         stall_i,
   mem_access_if.master       dbus,
   output logic [4:0]         reg_waddr_o,
   output logic               reg_we_o,
   output logic [31:0]        reg_wdata_o,
   output logic               stallreq_o,
   output logic               misalign_o,
   output logic [1:0]         dbg_state
);

   localparam logic [3:0] OP_LB  = 4'd1;
   localparam logic [3:0] OP_LH  = 4'd2;
   localparam logic [3:0] OP_LW  = 4'd3;
   localparam logic [3:0] OP_LBU = 4'd4;
   localparam logic [3:0] OP_LHU = 4'd5;
   localparam logic [3:0] OP_SB  = 4'd6;
   localparam logic [3:0] OP_SH  = 4'd7;
   localparam logic [3:0] OP_SW  = 4'd8;

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_WAIT = 2'd2, S_DONE = 2'd3} state_t;

   state_t      state_q, state_d;
   logic        is_load, is_store, misalign, start;
   logic [3:0]  be_d;
   logic [31:0] wdata_d;
   logic [31:0] addr_q, wdata_q, result_q, load_ext;
   logic [3:0]  be_q, op_q;
   logic [1:0]  off_q;
   logic        store_q, we_q;
   logic [4:0]  waddr_q;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic        unused_inputs;

   // The store flag duplicates what the op code already says; only the MEM/WB hold bit matters here.
   assign unused_inputs = ^{mem_we_i, stall_i[5], stall_i[3:0]};

   assign is_load  = (mem_op_i >= OP_LB) && (mem_op_i <= OP_LHU);
   assign is_store = (mem_op_i >= OP_SB) && (mem_op_i <= OP_SW);
   assign start    = (is_load || is_store) && !misalign;

   always_comb begin
      be_d     = 4'b0000;
      wdata_d  = 32'h0;
      misalign = 1'b0;
      case (mem_op_i)
         OP_LB, OP_LBU: be_d = 4'b0001 << mem_addr_i[1:0];
         OP_SB: begin
            be_d    = 4'b0001 << mem_addr_i[1:0];
            wdata_d = {4{mem_data_i[7:0]}};
         end
         OP_LH, OP_LHU: begin
            be_d     = mem_addr_i[1] ? 4'b1100 : 4'b0011;
            misalign = mem_addr_i[0];
         end
         OP_SH: begin
            be_d     = mem_addr_i[1] ? 4'b1100 : 4'b0011;
            wdata_d  = {2{mem_data_i[15:0]}};
            misalign = mem_addr_i[0];
         end
         OP_LW: begin
            be_d     = 4'b1111;
            misalign = |mem_addr_i[1:0];
         end
         OP_SW: begin
            be_d     = 4'b1111;
            wdata_d  = mem_data_i;
            misalign = |mem_addr_i[1:0];
         end
         default: ;
      endcase
   end

   assign byte_sel = dbus.rdata[{off_q, 3'b000} +: 8];
   assign half_sel = off_q[1] ? dbus.rdata[31:16] : dbus.rdata[15:0];

   always_comb begin
      case (op_q)
         OP_LB:   load_ext = {{24{byte_sel[7]}}, byte_sel};
         OP_LBU:  load_ext = {24'h0, byte_sel};
         OP_LH:   load_ext = {{16{half_sel[15]}}, half_sel};
         OP_LHU:  load_ext = {16'h0, half_sel};
         default: load_ext = dbus.rdata;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (start) state_d = S_REQ;
         S_REQ:  if (dbus.gnt) state_d = store_q ? S_DONE : S_WAIT;
         S_WAIT: if (dbus.rvalid) state_d = S_DONE;
         S_DONE: if (!stall_i[4]) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Request fields are captured once in IDLE so the bus sees them stable however long gnt takes.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         addr_q   <= 32'h0;
         be_q     <= 4'h0;
         wdata_q  <= 32'h0;
         op_q     <= 4'h0;
         off_q    <= 2'b00;
         store_q  <= 1'b0;
         we_q     <= 1'b0;
         waddr_q  <= 5'h0;
         result_q <= 32'h0;
      end else begin
         if (state_q == S_IDLE && start) begin
            addr_q  <= {mem_addr_i[31:2], 2'b00};
            be_q    <= be_d;
            wdata_q <= wdata_d;
            op_q    <= mem_op_i;
            off_q   <= mem_addr_i[1:0];
            store_q <= is_store;
            we_q    <= reg_we_i;
            waddr_q <= reg_waddr_i;
         end
         if (state_q == S_WAIT && dbus.rvalid) begin
            result_q <= load_ext;
         end
      end
   end

   // Every output is gated by reset so even the combinational pass-through reads zero in reset.
   always_comb begin
      dbus.req    = 1'b0;
      dbus.we     = 1'b0;
      dbus.addr   = 32'h0;
      dbus.be     = 4'h0;
      dbus.wdata  = 32'h0;
      reg_waddr_o = 5'h0;
      reg_we_o    = 1'b0;
      reg_wdata_o = 32'h0;
      stallreq_o  = 1'b0;
      misalign_o  = 1'b0;
      dbg_state   = 2'b00;
      if (rst_ni) begin
         dbg_state = state_q;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  stallreq_o = 1'b1;
               end else begin
                  reg_waddr_o = reg_waddr_i;
                  reg_wdata_o = reg_wdata_i;
                  misalign_o  = misalign;
                  reg_we_o    = reg_we_i && !misalign;
               end
            end
            S_REQ: begin
               dbus.req   = 1'b1;
               dbus.we    = store_q;
               dbus.addr  = addr_q;
               dbus.be    = be_q;
               dbus.wdata = wdata_q;
               stallreq_o = 1'b1;
            end
            S_WAIT: stallreq_o = 1'b1;
            S_DONE: begin
               reg_waddr_o = waddr_q;
               reg_we_o    = we_q;
               reg_wdata_o = store_q ? reg_wdata_i : result_q;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: loads, stores, misalignment, MEM/WB hold and reset mid-access.
module tb_mem_access;

   localparam logic [3:0] OP_NOP = 4'd0;
   localparam logic [3:0] OP_LB  = 4'd1;
   localparam logic [3:0] OP_LH  = 4'd2;
   localparam logic [3:0] OP_LW  = 4'd3;
   localparam logic [3:0] OP_LBU = 4'd4;
   localparam logic [3:0] OP_LHU = 4'd5;
   localparam logic [3:0] OP_SB  = 4'd6;
   localparam logic [3:0] OP_SH  = 4'd7;
   localparam logic [3:0] OP_SW  = 4'd8;

   logic        clk;
   logic        rst_n;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_data;
   logic [3:0]  mem_op;
   logic [4:0]  reg_waddr;
   logic        reg_we;
   logic [31:0] reg_wdata;
   logic [5:0]  stall;
   logic [4:0]  reg_waddr_o;
   logic        reg_we_o;
   logic [31:0] reg_wdata_o;
   logic        stallreq;
   logic        misalign;
   logic [1:0]  dbg_state;

   int n_checks;
   int n_errors;

   mem_access_if bus ();

   mem_access dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .mem_we_i    (mem_we),
      .mem_addr_i  (mem_addr),
      .mem_data_i  (mem_data),
      .mem_op_i    (mem_op),
      .reg_waddr_i (reg_waddr),
      .reg_we_i    (reg_we),
      .reg_wdata_i (reg_wdata),
      .stall_i     (stall),
      .dbus        (bus),
      .reg_waddr_o (reg_waddr_o),
      .reg_we_o    (reg_we_o),
      .reg_wdata_o (reg_wdata_o),
      .stallreq_o  (stallreq),
      .misalign_o  (misalign),
      .dbg_state   (dbg_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   // One aligned access from IDLE through DONE back to IDLE; gnt/rvalid delays and MEM/WB hold are directed.
   task automatic access(input string tag, input logic [3:0] op, input logic [31:0] addr,
                         input logic [31:0] data, input logic [31:0] rdata,
                         input int gnt_dly, input int rv_dly, input int hold,
                         input logic [3:0] exp_be, input logic [31:0] exp_addr,
                         input logic [31:0] exp_wdata, input logic [31:0] exp_res);
      bit          is_st;
      int          stall_cycles;
      logic [31:0] exp_wb;
      is_st      = (op >= OP_SB);
      mem_op     = op;
      mem_addr   = addr;
      mem_data   = data;
      mem_we     = is_st;
      reg_waddr  = 5'd9;
      reg_we     = !is_st;
      reg_wdata  = 32'h5A5A0000 ^ addr;
      exp_wb     = is_st ? reg_wdata : exp_res;
      #1;
      check({tag, " idle_stallreq"}, stallreq, 1'b1);
      check({tag, " idle_noreq"}, bus.req, 1'b0);
      stall_cycles = 1;
      @(negedge clk);
      for (int i = 0; i <= gnt_dly; i++) begin
         check({tag, " req_state"}, dbg_state, 2'd1);
         check({tag, " req"}, bus.req, 1'b1);
         check({tag, " req_we"}, bus.we, is_st);
         check({tag, " req_addr"}, bus.addr, exp_addr);
         check({tag, " req_be"}, bus.be, exp_be);
         if (is_st) check({tag, " req_wdata"}, bus.wdata, exp_wdata);
         if (stallreq) stall_cycles++;
         bus.gnt    = (i == gnt_dly);
         bus.rvalid = (i < gnt_dly);
         bus.rdata  = 32'hBAD0BAD0;
         @(negedge clk);
      end
      bus.gnt    = 1'b0;
      bus.rvalid = 1'b0;
      if (!is_st) begin
         for (int i = 0; i <= rv_dly; i++) begin
            check({tag, " wait_state"}, dbg_state, 2'd2);
            check({tag, " wait_noreq"}, bus.req, 1'b0);
            if (stallreq) stall_cycles++;
            bus.rvalid = (i == rv_dly);
            bus.rdata  = (i == rv_dly) ? rdata : 32'hBAD0BAD0;
            @(negedge clk);
         end
         bus.rvalid = 1'b0;
         bus.rdata  = 32'h0;
      end
      check({tag, " stall_cycles"}, stall_cycles, is_st ? (2 + gnt_dly) : (3 + gnt_dly + rv_dly));
      for (int i = 0; i <= hold; i++) begin
         check({tag, " done_state"}, dbg_state, 2'd3);
         check({tag, " done_stallreq"}, stallreq, 1'b0);
         check({tag, " done_wdata"}, reg_wdata_o, exp_wb);
         check({tag, " done_we"}, reg_we_o, !is_st);
         check({tag, " done_waddr"}, reg_waddr_o, 5'd9);
         stall = (i < hold) ? 6'b010000 : 6'b000000;
         @(negedge clk);
      end
      check({tag, " back_idle"}, dbg_state, 2'd0);
      mem_op = OP_NOP;
      reg_we = 1'b0;
      #1;
   endtask

   initial begin
      n_checks   = 0;
      n_errors   = 0;
      rst_n      = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = 32'h0;
      mem_data   = 32'h0;
      mem_op     = OP_NOP;
      reg_waddr  = 5'd4;
      reg_we     = 1'b1;
      reg_wdata  = 32'hA5A5A5A5;
      stall      = 6'b0;
      bus.gnt    = 1'b0;
      bus.rvalid = 1'b0;
      bus.rdata  = 32'h0;

      repeat (3) @(negedge clk);
      check("rst_state", dbg_state, 2'd0);
      check("rst_req", bus.req, 1'b0);
      check("rst_reg_we", reg_we_o, 1'b0);
      check("rst_reg_wdata", reg_wdata_o, 32'h0);
      check("rst_reg_waddr", reg_waddr_o, 5'd0);
      check("rst_stallreq", stallreq, 1'b0);
      rst_n = 1'b1;
      #1;

      check("nop_wdata", reg_wdata_o, 32'hA5A5A5A5);
      check("nop_we", reg_we_o, 1'b1);
      check("nop_waddr", reg_waddr_o, 5'd4);
      check("nop_stallreq", stallreq, 1'b0);
      mem_op = 4'd12;
      #1;
      check("op12_stallreq", stallreq, 1'b0);
      check("op12_wdata", reg_wdata_o, 32'hA5A5A5A5);
      @(negedge clk);
      check("op12_state", dbg_state, 2'd0);
      mem_op = OP_NOP;

      access("lb103",  OP_LB,  32'h103, 32'h0, 32'h80AABBCC, 0, 0, 0, 4'b1000, 32'h100, 32'h0, 32'hFFFFFF80);
      access("lhu202", OP_LHU, 32'h202, 32'h0, 32'h9234ABCD, 0, 0, 0, 4'b1100, 32'h200, 32'h0, 32'h00009234);
      access("lh202",  OP_LH,  32'h202, 32'h0, 32'h9234ABCD, 1, 0, 0, 4'b1100, 32'h200, 32'h0, 32'hFFFF9234);
      access("lbu102", OP_LBU, 32'h102, 32'h0, 32'h80AABBCC, 0, 1, 0, 4'b0100, 32'h100, 32'h0, 32'h000000AA);
      access("sh10",   OP_SH,  32'h10,  32'h1234BEEF, 32'h0, 3, 0, 0, 4'b0011, 32'h10, 32'hBEEFBEEF, 32'h0);
      access("sb21",   OP_SB,  32'h21,  32'h000000A5, 32'h0, 0, 0, 0, 4'b0010, 32'h20, 32'hA5A5A5A5, 32'h0);
      access("sw44",   OP_SW,  32'h44,  32'h13579BDF, 32'h0, 1, 0, 0, 4'b1111, 32'h44, 32'h13579BDF, 32'h0);
      access("lw40",   OP_LW,  32'h40,  32'h0, 32'hCAFEF00D, 0, 2, 2, 4'b1111, 32'h40, 32'h0, 32'hCAFEF00D);

      mem_op    = OP_SW;
      mem_addr  = 32'h6;
      mem_we    = 1'b1;
      reg_we    = 1'b1;
      #1;
      check("mis_sw_flag", misalign, 1'b1);
      check("mis_sw_req", bus.req, 1'b0);
      check("mis_sw_we", reg_we_o, 1'b0);
      check("mis_sw_stallreq", stallreq, 1'b0);
      @(negedge clk);
      check("mis_sw_state", dbg_state, 2'd0);
      check("mis_sw_req2", bus.req, 1'b0);
      mem_op   = OP_LH;
      mem_addr = 32'h201;
      mem_we   = 1'b0;
      #1;
      check("mis_lh_flag", misalign, 1'b1);
      check("mis_lh_stallreq", stallreq, 1'b0);
      mem_op = OP_NOP;
      #1;
      check("mis_clear", misalign, 1'b0);
      @(negedge clk);

      mem_op    = OP_LW;
      mem_addr  = 32'h80;
      reg_waddr = 5'd3;
      reg_we    = 1'b1;
      @(negedge clk);
      check("rw_req_state", dbg_state, 2'd1);
      bus.gnt = 1'b1;
      @(negedge clk);
      bus.gnt = 1'b0;
      check("rw_wait_state", dbg_state, 2'd2);
      rst_n     = 1'b0;
      mem_op    = OP_NOP;
      reg_wdata = 32'h11112222;
      #1;
      check("rw_rst_state", dbg_state, 2'd0);
      check("rw_rst_req", bus.req, 1'b0);
      check("rw_rst_stallreq", stallreq, 1'b0);
      check("rw_rst_reg_we", reg_we_o, 1'b0);
      check("rw_rst_reg_wdata", reg_wdata_o, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("rw_pass_wdata", reg_wdata_o, 32'h11112222);
      bus.rvalid = 1'b1;
      bus.rdata  = 32'hDEADBEEF;
      @(negedge clk);
      bus.rvalid = 1'b0;
      check("rw_ignore_state", dbg_state, 2'd0);
      check("rw_ignore_wdata", reg_wdata_o, 32'h11112222);
      check("rw_ignore_stallreq", stallreq, 1'b0);

      access("lb_after_rst", OP_LB, 32'h101, 32'h0, 32'h00007F00, 0, 0, 0, 4'b0010, 32'h100, 32'h0, 32'h0000007F);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
